// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/interrupt sequencer with level/edge pending bits and a drain/take/flush FSM.
// Optional TRAP_CTRL_NMI_EN adds a rising-edge NMI with top priority.
module trap_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int CAUSE_W = 6,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] irq_clr,
    input  logic               ei,
    input  logic               inst_valid,
    input  logic               stall,
    input  logic               exc_sync,
    input  logic [CAUSE_W-1:0] exc_sync_cause,
    input  logic               sret,
`ifdef TRAP_CTRL_NMI_EN
    input  logic               nmi,
    input  logic [CAUSE_W-1:0] nmi_cause,
`endif
    output logic [NUM_IRQ-1:0] ip,
    output logic               busy,
    output logic               trap_take,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic               trap_is_irq,
    output logic               sret_take
);
    typedef enum logic [1:0] {IDLE, DRAIN, TAKE, FLUSH} state_t;
    state_t r_state, w_state_nxt;
    logic [NUM_IRQ-1:0] r_ip, r_prev, w_ip_nxt, w_masked, w_take_clr;
    logic [CAUSE_W-1:0] r_cause, w_irq_cause, w_cause_sel;
    logic r_is_irq, r_sret_take, w_irq_pend, w_evt, w_sret_evt, w_irq_sel, w_capture, w_take_irq;
`ifdef TRAP_CTRL_NMI_EN
    logic r_nmi_prev, r_nmi_pend, r_is_nmi;
    assign w_take_irq = (r_state == TAKE) & r_is_irq & ~r_is_nmi;
    assign w_evt      = inst_valid & (r_nmi_pend | w_irq_pend | exc_sync);
`else
    assign w_take_irq = (r_state == TAKE) & r_is_irq;
    assign w_evt      = inst_valid & (w_irq_pend | exc_sync);
`endif
    assign w_masked   = r_ip & irq_en;
    assign w_irq_pend = ei & |w_masked;
    assign w_sret_evt = inst_valid & sret & ~stall & ~w_evt;
    assign w_capture  = (r_state == IDLE) & w_evt;
    // lowest set index wins, so scan from the top down
    always_comb begin
        w_irq_cause = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (w_masked[i]) w_irq_cause = CAUSE_W'(i);
    end
    always_comb begin
        w_take_clr = '0;
        w_ip_nxt   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_take_clr[i] = w_take_irq & (r_cause == CAUSE_W'(i));
            w_ip_nxt[i]   = IRQ_EDGE[i] ? ((irq_in[i] & ~r_prev[i]) | (r_ip[i] & ~irq_clr[i] & ~w_take_clr[i]))
                                        : irq_in[i];
        end
    end
    always_comb begin
        w_cause_sel = w_irq_pend ? w_irq_cause : exc_sync_cause;
        w_irq_sel   = w_irq_pend;
`ifdef TRAP_CTRL_NMI_EN
        if (r_nmi_pend) begin
            w_cause_sel = nmi_cause;
            w_irq_sel   = 1'b1;
        end
`endif
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_evt ? (stall ? DRAIN : TAKE) : (w_sret_evt ? FLUSH : IDLE);
            DRAIN:   w_state_nxt = stall ? DRAIN : TAKE;
            TAKE:    w_state_nxt = FLUSH;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ip        <= '0;
            r_prev      <= '0;
            r_cause     <= '0;
            r_is_irq    <= 1'b0;
            r_sret_take <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ip        <= w_ip_nxt;
            r_prev      <= irq_in;
            r_sret_take <= (r_state == IDLE) & w_sret_evt;
            if (w_capture) begin
                r_cause  <= w_cause_sel;
                r_is_irq <= w_irq_sel;
            end
        end
    end
`ifdef TRAP_CTRL_NMI_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nmi_prev <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_is_nmi   <= 1'b0;
        end else begin
            r_nmi_prev <= nmi;
            r_nmi_pend <= (nmi & ~r_nmi_prev) | (r_nmi_pend & ~((r_state == TAKE) & r_is_nmi));
            if (w_capture) r_is_nmi <= r_nmi_pend;
        end
    end
`endif
    assign ip          = r_ip;
    assign busy        = (r_state != IDLE);
    assign trap_take   = (r_state == TAKE);
    assign trap_cause  = r_cause;
    assign trap_is_irq = r_is_irq;
    assign sret_take   = r_sret_take;
endmodule
